// File: rtl/fpu_wb_queue.sv
// Writeback queue between the FP adder and the FP register-file write port, with sticky
// FCSR flags and a RAW scoreboard probe. Optional same-cycle bypass: FPU_WB_BYPASS_EN.
module fpu_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic [TAG_W-1:0]         in_rd,
  input  logic [4:0]               in_flags,
  input  logic                     wr_grant,
  output logic                     wr_en,
  output logic [TAG_W-1:0]         wr_addr,
  output logic [31:0]              wr_data,
  input  logic                     flush,
  input  logic [TAG_W-1:0]         query_rd,
  output logic                     query_hit,
  input  logic                     flags_clr,
  output logic [4:0]               fflags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;

  logic [TAG_W-1:0] rd_mem    [DEPTH];
  logic [31:0]      data_mem  [DEPTH];
  logic [4:0]       flags_mem [DEPTH];

  logic       empty, push, pop, bypass;
  logic [4:0] wr_flags;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CntW'(DEPTH));
  assign count    = count_q;
  assign fflags   = fflags_q;

`ifdef FPU_WB_BYPASS_EN
  assign bypass = empty && in_valid && wr_grant && !flush && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = !empty && wr_grant && !flush;
  // A bypassed result goes straight to the port and never occupies a slot.
  assign push = in_valid && in_ready && !flush && !bypass;

  always_comb begin
    wr_en    = pop || bypass;
    wr_addr  = '0;
    wr_data  = '0;
    wr_flags = '0;
    if (bypass) begin
      wr_addr  = in_rd;
      wr_data  = in_data;
      wr_flags = in_flags;
    end else if (!empty) begin
      wr_addr  = rd_mem[head_q];
      wr_data  = data_mem[head_q];
      wr_flags = flags_mem[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // A CSR clear coinciding with a write keeps that write's flags.
  always_comb begin
    fflags_d = fflags_q;
    if (flags_clr) fflags_d = wr_en ? wr_flags : 5'b0;
    else if (wr_en) fflags_d = fflags_q | wr_flags;
  end

  always_comb begin
    logic [PtrW-1:0] off;
    off       = '0;
    query_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = PtrW'(i) - head_q;
      if (({1'b0, off} < count_q) && (rd_mem[i] == query_rd)) query_hit = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[tail_q]    <= in_rd;
      data_mem[tail_q]  <= in_data;
      flags_mem[tail_q] <= in_flags;
    end
  end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Self-checking bench for fpu_wb_queue: directed table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_fpu_wb_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0, in_ready;
  logic [31:0]       in_data = '0;
  logic [TAG_W-1:0]  in_rd = '0;
  logic [4:0]        in_flags = '0;
  logic              wr_grant = 1'b0, wr_en;
  logic [TAG_W-1:0]  wr_addr;
  logic [31:0]       wr_data;
  logic              flush = 1'b0;
  logic [TAG_W-1:0]  query_rd = '0;
  logic              query_hit;
  logic              flags_clr = 1'b0;
  logic [4:0]        fflags;
  logic [2:0]        count;

  always #5 clock = ~clock;

  fpu_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_flags(in_flags), .wr_grant(wr_grant),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
    .query_rd(query_rd), .query_hit(query_hit), .flags_clr(flags_clr),
    .fflags(fflags), .count(count)
  );

  int   checks = 0;
  int   passed = 0;
  logic allow_ovf = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  fl;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] mf = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [4:0] rd,
                     input logic [4:0] fl, input logic g, input logic fls,
                     input logic clr, input logic [4:0] qrd);
    ent_t e;
    logic exp_wr, byp, hit;
    int   sz;
    @(negedge clock);
    in_valid = v; in_data = d; in_rd = rd; in_flags = fl;
    wr_grant = g; flush = fls; flags_clr = clr; query_rd = qrd;
    #1;
    sz  = mq.size();
    byp = 1'b0;
`ifdef FPU_WB_BYPASS_EN
    byp = (sz == 0) && v && g && !fls;
`endif
    if (v && sz >= int'(DEPTH) && !allow_ovf) begin
      checks++;
      $display("FAIL protocol: in_valid=1 while queue full (in_ready=%0b)", in_ready);
    end
    exp_wr = ((sz != 0) && g && !fls) || byp;
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].rd == qrd) hit = 1'b1;
    chk("count", 32'(count), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz < int'(DEPTH)));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("query_hit", 32'(query_hit), 32'(hit));
    chk("fflags", 32'(fflags), 32'(mf));
    if (byp) begin
      e.rd = rd; e.d = d; e.fl = fl;
    end else if (sz != 0) begin
      e = mq[0];
    end else begin
      e.rd = '0; e.d = '0; e.fl = '0;
    end
    if (exp_wr || sz == 0) begin
      chk("wr_addr", 32'(wr_addr), 32'(e.rd));
      chk("wr_data", wr_data, e.d);
    end
    if (clr) mf = exp_wr ? e.fl : 5'b0;
    else if (exp_wr) mf = mf | e.fl;
    if (fls) begin
      mq.delete();
    end else begin
      if (exp_wr && !byp) void'(mq.pop_front());
      if (v && sz < int'(DEPTH) && !byp) mq.push_back('{rd, d, fl});
    end
  endtask

  task automatic idle(input logic g, input logic [4:0] qrd);
    cyc(1'b0, 32'h0, 5'd0, 5'd0, g, 1'b0, 1'b0, qrd);
  endtask

  task automatic put(input logic [31:0] d, input logic [4:0] rd, input logic [4:0] fl);
    cyc(1'b1, d, rd, fl, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        g;
    int unsigned cnt;
    logic        rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [4:0] saved;
    tbl[0] = '{1'b1, 32'h3F800000, 5'd1, 1'b0, 0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{1'b1, 32'h40000000, 5'd2, 1'b0, 1, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[2] = '{1'b1, 32'h40400000, 5'd3, 1'b0, 2, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[3] = '{1'b1, 32'h40800000, 5'd4, 1'b0, 3, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[4] = '{1'b1, 32'h40A00000, 5'd5, 1'b0, 4, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[5] = '{1'b0, 32'h0,        5'd0, 1'b1, 4, 1'b0, 1'b1, 5'd1, 32'h3F800000};
    tbl[6] = '{1'b0, 32'h0,        5'd0, 1'b1, 3, 1'b1, 1'b1, 5'd2, 32'h40000000};
    tbl[7] = '{1'b0, 32'h0,        5'd0, 1'b1, 2, 1'b1, 1'b1, 5'd3, 32'h40400000};
    tbl[8] = '{1'b0, 32'h0,        5'd0, 1'b1, 1, 1'b1, 1'b1, 5'd4, 32'h40800000};
    tbl[9] = '{1'b0, 32'h0,        5'd0, 1'b0, 0, 1'b1, 1'b0, 5'd0, 32'h0};

    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_query_hit", 32'(query_hit), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Fill with grant low, refuse a 5th push, then drain in order.
    for (int i = 0; i < 10; i++) begin
      allow_ovf = (i == 4);
      cyc(tbl[i].v, tbl[i].d, tbl[i].rd, 5'd0, tbl[i].g, 1'b0, 1'b0, 5'd0);
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].rdy));
      chk("tbl_wr_en", 32'(wr_en), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk("tbl_wr_addr", 32'(wr_addr), 32'(tbl[i].addr));
        chk("tbl_wr_data", wr_data, tbl[i].data);
      end
    end
    allow_ovf = 1'b0;

    // Steady push+pop at occupancy 2; pointers wrap several times.
    put(32'hA0, 5'd20, 5'd0);
    put(32'hA1, 5'd21, 5'd0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 32'h1000 + 32'(k), 5'(k + 2), 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
      chk("pp_count", 32'(count), 32'd2);
    end
    idle(1'b1, 5'd0);
    idle(1'b1, 5'd0);
    idle(1'b0, 5'd0);

    // Sticky flag accumulation, then clear coinciding with a write.
    cyc(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    put(32'h11, 5'd1, 5'b00001);
    put(32'h22, 5'd2, 5'b10000);
    idle(1'b1, 5'd0);
    idle(1'b1, 5'd0);
    idle(1'b0, 5'd0);
    chk("sticky_or", 32'(fflags), 32'b10001);
    put(32'h33, 5'd3, 5'b00100);
    cyc(1'b0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0);
    idle(1'b0, 5'd0);
    chk("clr_with_write", 32'(fflags), 32'b00100);

    // Scoreboard probe.
    put(32'h77, 5'd7, 5'd0);
    put(32'h99, 5'd9, 5'd0);
    idle(1'b0, 5'd9);
    chk("sb_hit9", 32'(query_hit), 32'd1);
    idle(1'b0, 5'd8);
    chk("sb_miss8", 32'(query_hit), 32'd0);
    idle(1'b1, 5'd9);
    idle(1'b1, 5'd9);
    idle(1'b0, 5'd9);
    chk("sb_drained9", 32'(query_hit), 32'd0);

    // Flush with 3 entries and a concurrent push.
    put(32'h51, 5'd11, 5'b01000);
    put(32'h52, 5'd12, 5'b01000);
    put(32'h53, 5'd13, 5'b01000);
    saved = mf;
    cyc(1'b1, 32'h54, 5'd14, 5'b00010, 1'b1, 1'b1, 1'b0, 5'd0);
    chk("flush_wr_en", 32'(wr_en), 32'd0);
    idle(1'b1, 5'd14);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_fflags", 32'(fflags), 32'(saved));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic v, g, fls, clr;
      v   = ($urandom_range(0, 3) != 0) && (mq.size() < int'(DEPTH));
      g   = ($urandom_range(0, 9) < 6);
      fls = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 19) == 0);
      cyc(v, $urandom, 5'($urandom_range(0, 7)), 5'($urandom), g, fls, clr,
          5'($urandom_range(0, 7)));
    end
    cyc(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);

    // Asynchronous reset between two granted writes.
    put(32'hC1, 5'd21, 5'b00001);
    put(32'hC2, 5'd22, 5'b00001);
    idle(1'b1, 5'd22);
    @(negedge clock);
    in_valid = 1'b0; wr_grant = 1'b1; query_rd = 5'd22;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    mf = '0;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_fflags", 32'(fflags), 32'd0);
    chk("arst_query_hit", 32'(query_hit), 32'd0);
    chk("arst_wr_addr", 32'(wr_addr), 32'd0);
    @(posedge clock);
    #1;
    chk("arst_hold_wr_en", 32'(wr_en), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(1'b1, 5'd22);

`ifdef FPU_WB_BYPASS_EN
    cyc(1'b1, 32'h40490FDB, 5'd3, 5'b00001, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("bp_wr_en", 32'(wr_en), 32'd1);
    chk("bp_wr_addr", 32'(wr_addr), 32'd3);
    chk("bp_wr_data", wr_data, 32'h40490FDB);
    idle(1'b0, 5'd3);
    chk("bp_count", 32'(count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
